// File: rtl/lemming_world.sv
// Terrain environment for the Lemmings walker FSM: holds ground/wall maps, tracks
// position and level, and feeds bump/ground back to the FSM from registered state only.
module lemming_world #(
    parameter int               WIDTH       = 16,
    parameter int               POS_W       = 4,
    parameter int               START_POS   = 4,
    parameter logic [WIDTH-1:0] INIT_GROUND = 16'hFFFF,
    parameter logic [WIDTH-1:0] INIT_WALL   = 16'h0000,
    parameter int               DIG_CYCLES  = 3,
    parameter int               FALL_CYCLES = 4,
    parameter int               MAX_LEVEL   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             walk_left_i,
    input  logic             walk_right_i,
    input  logic             aaah_i,
    input  logic             digging_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_ground_i,
    input  logic [WIDTH-1:0] load_wall_i,
    output logic             bump_left_o,
    output logic             bump_right_o,
    output logic             ground_o,
    output logic [POS_W-1:0] pos_o,
    output logic [1:0]       level_o,
    output logic             proto_err_o
);

    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] POS_START = POS_W'(START_POS);
    localparam logic [1:0]       LVL_MAX   = 2'(MAX_LEVEL);
    localparam logic [1:0]       DIG_LAST  = 2'(DIG_CYCLES - 1);
    localparam logic [2:0]       FALL_LAST = 3'(FALL_CYCLES - 1);

    logic [WIDTH-1:0] gmap_q, gmap_d;
    logic [WIDTH-1:0] wmap_q, wmap_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [1:0]       level_q, level_d;
    logic [1:0]       dig_q, dig_d;
    logic [2:0]       fall_q, fall_d;
    logic             err_q, err_d;

    logic [POS_W-1:0] posLeft;
    logic [POS_W-1:0] posRight;
    logic             conflict;

    assign posLeft  = pos_q - POS_ONE;
    assign posRight = pos_q + POS_ONE;

    // Array edges read as walls; the neighbour index is only used when it is in range.
    assign bump_left_o  = (pos_q == '0)      ? 1'b1 : wmap_q[posLeft];
    assign bump_right_o = (pos_q == POS_LAST) ? 1'b1 : wmap_q[posRight];
    assign ground_o     = gmap_q[pos_q];
    assign pos_o        = pos_q;
    assign level_o      = level_q;
    assign proto_err_o  = err_q;

    assign conflict = (walk_left_i & walk_right_i) |
                      (aaah_i & (walk_left_i | walk_right_i | digging_i));

    always_comb begin
        gmap_d  = gmap_q;
        wmap_d  = wmap_q;
        pos_d   = pos_q;
        level_d = level_q;
        dig_d   = dig_q;
        fall_d  = fall_q;
        err_d   = err_q;

        if (load_i) begin
            gmap_d  = load_ground_i;
            wmap_d  = load_wall_i;
            pos_d   = POS_START;
            level_d = 2'd0;
            dig_d   = 2'd0;
            fall_d  = 3'd0;
        end else begin
            if (conflict) begin
                err_d = 1'b1;
            end

            if (!gmap_q[pos_q]) begin
                // Falling: only aaah advances the fall; anything else is a protocol slip.
                dig_d = 2'd0;
                if (aaah_i) begin
                    if (fall_q == FALL_LAST) begin
                        gmap_d[pos_q] = 1'b1;
                        level_d       = (level_q == LVL_MAX) ? LVL_MAX : level_q + 2'd1;
                        fall_d        = 3'd0;
                    end else begin
                        fall_d = fall_q + 3'd1;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end else if (aaah_i) begin
                dig_d = 2'd0;
            end else if (digging_i) begin
                if (level_q == LVL_MAX) begin
                    dig_d = 2'd0;
                end else if (dig_q == DIG_LAST) begin
                    gmap_d[pos_q] = 1'b0;
                    dig_d         = 2'd0;
                end else begin
                    dig_d = dig_q + 2'd1;
                end
            end else begin
                dig_d = 2'd0;
                if (!conflict) begin
                    if (walk_left_i && !bump_left_o) begin
                        pos_d = posLeft;
                    end else if (walk_right_i && !bump_right_o) begin
                        pos_d = posRight;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gmap_q  <= INIT_GROUND;
            wmap_q  <= INIT_WALL;
            pos_q   <= POS_START;
            level_q <= 2'd0;
            dig_q   <= 2'd0;
            fall_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            gmap_q  <= gmap_d;
            wmap_q  <= wmap_d;
            pos_q   <= pos_d;
            level_q <= level_d;
            dig_q   <= dig_d;
            fall_q  <= fall_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lemming_world.sv
// Self-checking bench for lemming_world: vector table plus scoreboard queue of
// expected outputs, with hand-written reset-mid-dig and interrupted-fall sequences.
module tb_lemming_world;

    typedef struct {
        logic [4:0]  op;      // {walk_left, walk_right, aaah, digging, load}
        logic [15:0] lg;
        logic [15:0] lw;
        logic [3:0]  pos;
        logic [1:0]  lvl;
        logic        gnd;
        logic        bl;
        logic        br;
        logic        err;
    } vec_t;

    typedef struct {
        logic [3:0] pos;
        logic [1:0] lvl;
        logic       gnd;
        logic       bl;
        logic       br;
        logic       err;
    } exp_t;

    localparam logic [4:0] IDLE = 5'b00000;
    localparam logic [4:0] WL   = 5'b10000;
    localparam logic [4:0] WR   = 5'b01000;
    localparam logic [4:0] WLR  = 5'b11000;
    localparam logic [4:0] AH   = 5'b00100;
    localparam logic [4:0] DG   = 5'b00010;
    localparam logic [4:0] LD   = 5'b00001;

    logic        clk;
    logic        rst;
    logic        walkLeft, walkRight, aaah, digging, load;
    logic [15:0] loadGround, loadWall;
    logic        bumpLeft, bumpRight, ground, protoErr;
    logic [3:0]  pos;
    logic [1:0]  level;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[$];

    lemming_world dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .walk_left_i   (walkLeft),
        .walk_right_i  (walkRight),
        .aaah_i        (aaah),
        .digging_i     (digging),
        .load_i        (load),
        .load_ground_i (loadGround),
        .load_wall_i   (loadWall),
        .bump_left_o   (bumpLeft),
        .bump_right_o  (bumpRight),
        .ground_o      (ground),
        .pos_o         (pos),
        .level_o       (level),
        .proto_err_o   (protoErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] op, input logic [15:0] lg, input logic [15:0] lw,
                                input logic [3:0] p, input logic [1:0] l, input logic g,
                                input logic bl, input logic br, input logic e);
        vec_t v;
        v.op = op; v.lg = lg; v.lw = lw;
        v.pos = p; v.lvl = l; v.gnd = g; v.bl = bl; v.br = br; v.err = e;
        return v;
    endfunction

    task automatic checkField(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic pushExpected(input vec_t v);
        exp_t e;
        e.pos = v.pos; e.lvl = v.lvl; e.gnd = v.gnd; e.bl = v.bl; e.br = v.br; e.err = v.err;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard at %0t: got empty queue expected an entry", $time);
            return;
        end
        e = sb.pop_front();
        checkField("pos",        int'(pos),       int'(e.pos));
        checkField("level",      int'(level),     int'(e.lvl));
        checkField("ground",     int'(ground),    int'(e.gnd));
        checkField("bump_left",  int'(bumpLeft),  int'(e.bl));
        checkField("bump_right", int'(bumpRight), int'(e.br));
        checkField("proto_err",  int'(protoErr),  int'(e.err));
    endtask

    task automatic applyStimulus(input vec_t v);
        {walkLeft, walkRight, aaah, digging, load} = v.op;
        loadGround = v.lg;
        loadWall   = v.lw;
        pushExpected(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Walk right to the far edge, then try once more.
        for (int k = 1; k <= 11; k++)
            tbl.push_back(mk(WR, 16'h0, 16'h0, 4'(4 + k), 2'd0, 1'b1, 1'b0, (k == 11), 1'b0));
        tbl.push_back(mk(WR,   16'h0,    16'h0,    4'd15, 2'd0, 1, 0, 1, 0));
        tbl.push_back(mk(WL,   16'h0,    16'h0,    4'd14, 2'd0, 1, 0, 0, 0));
        // Interior walls on both sides.
        tbl.push_back(mk(LD,   16'hFFFF, 16'h0040, 4'd4,  2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(WR,   16'h0,    16'h0,    4'd5,  2'd0, 1, 0, 1, 0));
        tbl.push_back(mk(WR,   16'h0,    16'h0,    4'd5,  2'd0, 1, 0, 1, 0));
        tbl.push_back(mk(WR,   16'h0,    16'h0,    4'd5,  2'd0, 1, 0, 1, 0));
        tbl.push_back(mk(LD,   16'hFFFF, 16'h0008, 4'd4,  2'd0, 1, 1, 0, 0));
        tbl.push_back(mk(WL,   16'h0,    16'h0,    4'd4,  2'd0, 1, 1, 0, 0));
        // Dig through level 0 at pos 4 and fall to level 1.
        tbl.push_back(mk(LD,   16'hFFFF, 16'h0000, 4'd4,  2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd4,  2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd4,  2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd4,  2'd0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(AH, 16'h0,  16'h0,    4'd4,  2'd0, 0, 0, 0, 0));
        tbl.push_back(mk(AH,   16'h0,    16'h0,    4'd4,  2'd1, 1, 0, 0, 0));
        tbl.push_back(mk(WR,   16'h0,    16'h0,    4'd5,  2'd1, 1, 0, 0, 0));
        // Interrupted dig restarts the count.
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd5,  2'd1, 1, 0, 0, 0));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd5,  2'd1, 1, 0, 0, 0));
        tbl.push_back(mk(IDLE, 16'h0,    16'h0,    4'd5,  2'd1, 1, 0, 0, 0));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd5,  2'd1, 1, 0, 0, 0));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd5,  2'd1, 1, 0, 0, 0));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd5,  2'd1, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(AH, 16'h0,  16'h0,    4'd5,  2'd1, 0, 0, 0, 0));
        tbl.push_back(mk(AH,   16'h0,    16'h0,    4'd5,  2'd2, 1, 0, 0, 0));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd5,  2'd2, 1, 0, 0, 0));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd5,  2'd2, 1, 0, 0, 0));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd5,  2'd2, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(AH, 16'h0,  16'h0,    4'd5,  2'd2, 0, 0, 0, 0));
        tbl.push_back(mk(AH,   16'h0,    16'h0,    4'd5,  2'd3, 1, 0, 0, 0));
        // Bedrock: digging has no effect.
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(DG, 16'h0,  16'h0,    4'd5,  2'd3, 1, 0, 0, 0));
        tbl.push_back(mk(WL,   16'h0,    16'h0,    4'd4,  2'd3, 1, 0, 0, 0));
        tbl.push_back(mk(WR,   16'h0,    16'h0,    4'd5,  2'd3, 1, 0, 0, 0));
        // Conflicting walk, sticky error, load keeps the error.
        tbl.push_back(mk(WLR,  16'h0,    16'h0,    4'd5,  2'd3, 1, 0, 0, 1));
        tbl.push_back(mk(IDLE, 16'h0,    16'h0,    4'd5,  2'd3, 1, 0, 0, 1));
        tbl.push_back(mk(LD,   16'hFFFF, 16'h0000, 4'd4,  2'd0, 1, 0, 0, 1));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd4,  2'd0, 1, 0, 0, 1));
        tbl.push_back(mk(DG,   16'h0,    16'h0,    4'd4,  2'd0, 1, 0, 0, 1));

        {walkLeft, walkRight, aaah, digging, load} = IDLE;
        loadGround = 16'h0;
        loadWall   = 16'h0;
        rst = 1'b1;
        #12;
        rst = 1'b0;
        pushExpected(mk(IDLE, 16'h0, 16'h0, 4'd4, 2'd0, 1, 0, 0, 0));
        checkOutput();

        foreach (tbl[i]) applyStimulus(tbl[i]);

        // Short reset pulse mid-dig (dig count at 2) clears everything at once.
        #2;
        rst = 1'b1;
        #1;
        pushExpected(mk(IDLE, 16'h0, 16'h0, 4'd4, 2'd0, 1, 0, 0, 0));
        checkOutput();
        rst = 1'b0;
        applyStimulus(mk(DG, 16'h0, 16'h0, 4'd4, 2'd0, 1, 0, 0, 0));
        applyStimulus(mk(DG, 16'h0, 16'h0, 4'd4, 2'd0, 1, 0, 0, 0));
        applyStimulus(mk(DG, 16'h0, 16'h0, 4'd4, 2'd0, 0, 0, 0, 0));

        // A missing aaah mid-fall flags an error and holds the fall count.
        applyStimulus(mk(AH,   16'h0, 16'h0, 4'd4, 2'd0, 0, 0, 0, 0));
        applyStimulus(mk(AH,   16'h0, 16'h0, 4'd4, 2'd0, 0, 0, 0, 0));
        applyStimulus(mk(IDLE, 16'h0, 16'h0, 4'd4, 2'd0, 0, 0, 0, 1));
        applyStimulus(mk(AH,   16'h0, 16'h0, 4'd4, 2'd0, 0, 0, 0, 1));
        applyStimulus(mk(AH,   16'h0, 16'h0, 4'd4, 2'd1, 1, 0, 0, 1));

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
